// File: rtl/regfile_pkg.sv
// Shared constants and types for the register-file write-port arbiter.
package regfile_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    localparam reg_addr_t ZERO_REG = 5'd0;

    typedef enum logic [1:0] {
        GRANT_NONE = 2'd0,
        GRANT_WB   = 2'd1,
        GRANT_LU   = 2'd2
    } grant_e;

endpackage

// File: rtl/regfile_write_arbiter_if.sv
// Bundle of the pipeline, long-latency unit, hazard-unit and register-file
// port signals of the write arbiter.
interface regfile_write_arbiter_if #(
    parameter int DATA_WIDTH = 32
);
    import regfile_pkg::*;

    logic                  wb_we;
    reg_addr_t             wb_addr;
    logic [DATA_WIDTH-1:0] wb_data;
    logic                  lu_valid;
    logic                  lu_ready;
    reg_addr_t             lu_addr;
    logic [DATA_WIDTH-1:0] lu_data;
    logic                  issue_set;
    reg_addr_t             issue_addr;
    reg_addr_t             pend_addr1;
    reg_addr_t             pend_addr2;
    logic                  pend_hit1;
    logic                  pend_hit2;
    logic                  wb_stall;
    logic                  WE3;
    reg_addr_t             A3;
    logic [DATA_WIDTH-1:0] WD3;

    modport master (
        output wb_we, wb_addr, wb_data,
        output lu_valid, lu_addr, lu_data,
        output issue_set, issue_addr, pend_addr1, pend_addr2,
        input  lu_ready, pend_hit1, pend_hit2, wb_stall, WE3, A3, WD3
    );

    modport slave (
        input  wb_we, wb_addr, wb_data,
        input  lu_valid, lu_addr, lu_data,
        input  issue_set, issue_addr, pend_addr1, pend_addr2,
        output lu_ready, pend_hit1, pend_hit2, wb_stall, WE3, A3, WD3
    );

endinterface

// File: rtl/regfile_wr_fifo.sv
// Small synchronous FIFO holding long-latency results (address + data);
// the head entry is presented combinationally.
module regfile_wr_fifo
    import regfile_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  reg_addr_t              push_addr,
    input  logic [DATA_WIDTH-1:0]  push_data,
    output reg_addr_t              head_addr,
    output logic [DATA_WIDTH-1:0]  head_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    reg_addr_t             addr_mem_q [DEPTH];
    reg_addr_t             addr_mem_d [DEPTH];
    logic [DATA_WIDTH-1:0] data_mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] data_mem_d [DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  do_push;
    logic                  do_pop;

    assign full      = (count_q == CNT_W'(DEPTH));
    assign empty     = (count_q == {CNT_W{1'b0}});
    assign count     = count_q;
    assign head_addr = addr_mem_q[rd_ptr_q];
    assign head_data = data_mem_q[rd_ptr_q];
    assign do_push   = push && !full;
    assign do_pop    = pop && !empty;

    // Next-state for storage, pointers (wrap naturally, DEPTH is a power of two) and count.
    always_comb begin
        addr_mem_d = addr_mem_q;
        data_mem_d = data_mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        if (do_push) begin
            addr_mem_d[wr_ptr_q] = push_addr;
            data_mem_d[wr_ptr_q] = push_data;
            wr_ptr_d             = wr_ptr_q + PTR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            count_q  <= {CNT_W{1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents are meaningless while count is zero.
    always_ff @(posedge clk) begin
        addr_mem_q <= addr_mem_d;
        data_mem_q <= data_mem_d;
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register-file write port between writeback and buffered
// long-latency results, with a pending scoreboard and starvation guard.
module regfile_write_arbiter
    import regfile_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    regfile_write_arbiter_if.slave  bus
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int SC_W  = $clog2(STARVE_MAX + 1);

    logic                  lu_ready_s;
    logic                  fifo_push;
    logic                  fifo_pop;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [CNT_W-1:0]      fifo_count;
    reg_addr_t             head_addr;
    logic [DATA_WIDTH-1:0] head_data;
    grant_e                grant;
    reg_addr_t             sel_addr;
    logic [DATA_WIDTH-1:0] sel_data;
    logic                  sel_we;
    logic [NUM_REGS-1:0]   pending_q, pending_d;
    logic [NUM_REGS-1:0]   clr_mask, set_mask;
    logic [SC_W-1:0]       starve_q, starve_d;
    logic                  starve_sat;

    regfile_wr_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .pop       (fifo_pop),
        .push_addr (bus.lu_addr),
        .push_data (bus.lu_data),
        .head_addr (head_addr),
        .head_data (head_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign lu_ready_s = (fifo_count < CNT_W'(FIFO_DEPTH)) && !rst;
    assign fifo_push  = bus.lu_valid && lu_ready_s && !fifo_full;

    // Grant mux: writeback first; buffered results are held back during reset so discarded entries never write.
    always_comb begin
        grant    = GRANT_NONE;
        sel_addr = ZERO_REG;
        sel_data = {DATA_WIDTH{1'b0}};
        fifo_pop = 1'b0;
        if (bus.wb_we) begin
            grant = GRANT_WB;
        end else if (!fifo_empty && !rst) begin
            grant = GRANT_LU;
        end else begin
            grant = GRANT_NONE;
        end
        case (grant)
            GRANT_WB: begin
                sel_addr = bus.wb_addr;
                sel_data = bus.wb_data;
            end
            GRANT_LU: begin
                sel_addr = head_addr;
                sel_data = head_data;
                fifo_pop = 1'b1;
            end
            default: begin
                sel_addr = ZERO_REG;
                sel_data = {DATA_WIDTH{1'b0}};
                fifo_pop = 1'b0;
            end
        endcase
        sel_we = (grant != GRANT_NONE) && (sel_addr != ZERO_REG);
    end

    assign bus.WE3      = sel_we;
    assign bus.A3       = sel_addr;
    assign bus.WD3      = sel_data;
    assign bus.lu_ready = lu_ready_s;

    // Scoreboard update: the set mask is OR-ed in after clearing so a same-cycle issue wins.
    always_comb begin
        clr_mask  = (fifo_pop && (head_addr != ZERO_REG))
                  ? ({{(NUM_REGS-1){1'b0}}, 1'b1} << head_addr) : {NUM_REGS{1'b0}};
        set_mask  = (bus.issue_set && (bus.issue_addr != ZERO_REG))
                  ? ({{(NUM_REGS-1){1'b0}}, 1'b1} << bus.issue_addr) : {NUM_REGS{1'b0}};
        pending_d = (pending_q & ~clr_mask) | set_mask;
    end

    // Starvation counter: counts denied cycles of a non-empty FIFO, saturating.
    always_comb begin
        starve_sat = (starve_q == SC_W'(STARVE_MAX));
        if (fifo_empty || fifo_pop) begin
            starve_d = {SC_W{1'b0}};
        end else if (!starve_sat) begin
            starve_d = starve_q + SC_W'(1);
        end else begin
            starve_d = starve_q;
        end
    end

    // Scoreboard and counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending_q <= {NUM_REGS{1'b0}};
            starve_q  <= {SC_W{1'b0}};
        end else begin
            pending_q <= pending_d;
            starve_q  <= starve_d;
        end
    end

    assign bus.wb_stall  = starve_sat && !fifo_empty && !rst;
    assign bus.pend_hit1 = pending_q[bus.pend_addr1] && (bus.pend_addr1 != ZERO_REG);
    assign bus.pend_hit2 = pending_q[bus.pend_addr2] && (bus.pend_addr2 != ZERO_REG);

endmodule
